// File: rtl/mem_port_arbiter.sv
// Shared memory-port arbiter between instruction fetch and the data stage.
// Grants one requester per transaction, holds the port until mem_ack or a watchdog timeout.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter bit DATA_FIRST = 1'b1,
    parameter int MAX_WAIT   = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              sel,
    output logic              busy,
    output logic              timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY_IF = 2'd1,
        S_BUSY_D  = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    // Counter value seen during the last permitted wait cycle.
    localparam logic [7:0]        WAIT_LAST    = 8'(MAX_WAIT - 1);
    localparam logic [DATA_W-1:0] TIMEOUT_DATA = DATA_W'(32'hDEADBEEF);

    state_t            state_q, state_d;
    logic              sel_q, sel_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_ack_q, if_ack_d;
    logic              d_ack_q, d_ack_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              busy_q, busy_d;
    logic              timeout_err_q, timeout_err_d;
    logic              last_owner_q, last_owner_d;
    logic [7:0]        wait_cnt_q, wait_cnt_d;

    logic              grant_any_s;
    logic              grant_d_s;
    logic              in_busy_s;
    logic              expired_s;
    logic              done_s;

    // Grant decision and transaction completion conditions.
    always_comb begin
        grant_any_s = if_req | d_req;
        if (if_req && d_req) begin
            grant_d_s = DATA_FIRST ? 1'b1 : ~last_owner_q;
        end else begin
            grant_d_s = d_req;
        end
        in_busy_s = (state_q == S_BUSY_IF) || (state_q == S_BUSY_D);
        expired_s = in_busy_s && !mem_ack && (wait_cnt_q == WAIT_LAST);
        done_s    = in_busy_s && (mem_ack || (wait_cnt_q == WAIT_LAST));
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (grant_any_s) begin
                    state_d = grant_d_s ? S_BUSY_D : S_BUSY_IF;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY_IF, S_BUSY_D: begin
                if (done_s) begin
                    state_d = S_RESP;
                end else begin
                    state_d = state_q;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Registered-output next values; everything holds unless a transition updates it.
    always_comb begin
        sel_d         = sel_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        if_ack_d      = 1'b0;
        d_ack_d       = 1'b0;
        if_rdata_d    = if_rdata_q;
        d_rdata_d     = d_rdata_q;
        timeout_err_d = timeout_err_q;
        last_owner_d  = last_owner_q;
        wait_cnt_d    = wait_cnt_q;
        busy_d        = (state_d != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (grant_any_s) begin
                    sel_d        = grant_d_s;
                    mem_req_d    = 1'b1;
                    mem_we_d     = grant_d_s & d_we;
                    mem_addr_d   = grant_d_s ? d_addr : if_addr;
                    mem_wdata_d  = grant_d_s ? d_wdata : {DATA_W{1'b0}};
                    wait_cnt_d   = 8'd0;
                    last_owner_d = grant_d_s;
                end else begin
                    mem_req_d = 1'b0;
                end
            end
            S_BUSY_IF, S_BUSY_D: begin
                if (done_s) begin
                    mem_req_d     = 1'b0;
                    timeout_err_d = timeout_err_q | expired_s;
                    if (sel_q) begin
                        d_ack_d = 1'b1;
                        if (!mem_we_q) begin
                            d_rdata_d = expired_s ? TIMEOUT_DATA : mem_rdata;
                        end else begin
                            d_rdata_d = d_rdata_q;
                        end
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = expired_s ? TIMEOUT_DATA : mem_rdata;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            S_RESP: begin
                mem_req_d = 1'b0;
            end
            default: begin
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            sel_q         <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= {ADDR_W{1'b0}};
            mem_wdata_q   <= {DATA_W{1'b0}};
            if_ack_q      <= 1'b0;
            d_ack_q       <= 1'b0;
            if_rdata_q    <= {DATA_W{1'b0}};
            d_rdata_q     <= {DATA_W{1'b0}};
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            last_owner_q  <= 1'b1;
            wait_cnt_q    <= 8'd0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            if_ack_q      <= if_ack_d;
            d_ack_q       <= d_ack_d;
            if_rdata_q    <= if_rdata_d;
            d_rdata_q     <= d_rdata_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
            last_owner_q  <= last_owner_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

    assign sel         = sel_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign if_ack      = if_ack_q;
    assign d_ack       = d_ack_q;
    assign if_rdata    = if_rdata_q;
    assign d_rdata     = d_rdata_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a round-robin instance (u0) and a data-first instance (u1)
// share stimulus; u0 is checked against a vector table, both against hand-written tie sequences.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ack = 1'b0;
    logic [31:0] if_addr = 32'd0, d_addr = 32'd0, d_wdata = 32'd0, mem_rdata = 32'd0;

    logic        if_ack, d_ack, mem_req, mem_we, sel, busy, timeout_err;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic        if_ack_1, d_ack_1, mem_req_1, mem_we_1, sel_1, busy_1, timeout_err_1;
    logic [31:0] if_rdata_1, d_rdata_1, mem_addr_1, mem_wdata_1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .DATA_FIRST(1'b0), .MAX_WAIT(15)) u0 (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .sel(sel), .busy(busy), .timeout_err(timeout_err)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .DATA_FIRST(1'b1), .MAX_WAIT(15)) u1 (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack_1), .if_rdata(if_rdata_1),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack_1), .d_rdata(d_rdata_1),
        .mem_req(mem_req_1), .mem_we(mem_we_1), .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .sel(sel_1), .busy(busy_1), .timeout_err(timeout_err_1)
    );

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        mem_ack;
        logic [31:0] mem_rdata;
        logic        e_mem_req;
        logic        e_sel;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_if_ack;
        logic        e_d_ack;
        logic [31:0] e_if_rdata;
        logic [31:0] e_d_rdata;
        logic        e_busy;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        if_req = 1'b0; if_addr = 32'd0; d_req = 1'b0; d_we = 1'b0;
        d_addr = 32'd0; d_wdata = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int cycles;

        // if_req,if_addr, d_req,d_we,d_addr,d_wdata, mem_ack,mem_rdata |
        // mem_req,sel,we,addr,wdata, if_ack,d_ack,if_rdata,d_rdata, busy
        vecs[0]  = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
                     1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1};
        vecs[1]  = '{1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
                     1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1};
        vecs[2]  = '{1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hA5A5A5A5,
                     1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 1'b1, 1'b0, 32'hA5A5A5A5, 32'h0, 1'b1};
        vecs[3]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
                     1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'hA5A5A5A5, 32'h0, 1'b0};
        vecs[4]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h1000, 32'h12345678, 1'b0, 32'h0,
                     1'b1, 1'b1, 1'b1, 32'h1000, 32'h12345678, 1'b0, 1'b0, 32'hA5A5A5A5, 32'h0, 1'b1};
        vecs[5]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h1000, 32'h12345678, 1'b1, 32'hCAFEF00D,
                     1'b0, 1'b1, 1'b1, 32'h1000, 32'h12345678, 1'b0, 1'b1, 32'hA5A5A5A5, 32'h0, 1'b1};
        vecs[6]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
                     1'b0, 1'b1, 1'b1, 32'h1000, 32'h12345678, 1'b0, 1'b0, 32'hA5A5A5A5, 32'h0, 1'b0};
        vecs[7]  = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h2000, 32'h0, 1'b0, 32'h0,
                     1'b1, 1'b1, 1'b0, 32'h2000, 32'h0, 1'b0, 1'b0, 32'hA5A5A5A5, 32'h0, 1'b1};
        vecs[8]  = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h2000, 32'h0, 1'b1, 32'h1234ABCD,
                     1'b0, 1'b1, 1'b0, 32'h2000, 32'h0, 1'b0, 1'b1, 32'hA5A5A5A5, 32'h1234ABCD, 1'b1};
        vecs[9]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0,
                     1'b0, 1'b1, 1'b0, 32'h2000, 32'h0, 1'b0, 1'b0, 32'hA5A5A5A5, 32'h1234ABCD, 1'b0};
        vecs[10] = '{1'b1, 32'h80, 1'b1, 1'b0, 32'h3000, 32'h0, 1'b0, 32'h0,
                     1'b1, 1'b0, 1'b0, 32'h80, 32'h0, 1'b0, 1'b0, 32'hA5A5A5A5, 32'h1234ABCD, 1'b1};
        vecs[11] = '{1'b1, 32'h80, 1'b1, 1'b0, 32'h3000, 32'h0, 1'b1, 32'h11111111,
                     1'b0, 1'b0, 1'b0, 32'h80, 32'h0, 1'b1, 1'b0, 32'h11111111, 32'h1234ABCD, 1'b1};
        vecs[12] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h3000, 32'h0, 1'b1, 32'h0,
                     1'b0, 1'b0, 1'b0, 32'h80, 32'h0, 1'b0, 1'b0, 32'h11111111, 32'h1234ABCD, 1'b0};
        vecs[13] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h3000, 32'h0, 1'b0, 32'h0,
                     1'b1, 1'b1, 1'b0, 32'h3000, 32'h0, 1'b0, 1'b0, 32'h11111111, 32'h1234ABCD, 1'b1};
        vecs[14] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h3000, 32'h0, 1'b1, 32'h22222222,
                     1'b0, 1'b1, 1'b0, 32'h3000, 32'h0, 1'b0, 1'b1, 32'h11111111, 32'h22222222, 1'b1};
        vecs[15] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0,
                     1'b0, 1'b1, 1'b0, 32'h3000, 32'h0, 1'b0, 1'b0, 32'h11111111, 32'h22222222, 1'b0};
        vecs[16] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0,
                     1'b0, 1'b1, 1'b0, 32'h3000, 32'h0, 1'b0, 1'b0, 32'h11111111, 32'h22222222, 1'b0};

        // Reset state
        do_reset();
        chk("rst mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst sel", {31'd0, sel}, 32'd0);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst mem_addr", mem_addr, 32'd0);
        chk("rst acks", {30'd0, if_ack, d_ack}, 32'd0);
        chk("rst rdata", if_rdata | d_rdata, 32'd0);
        chk("rst timeout_err", {31'd0, timeout_err}, 32'd0);

        // Vector table on the round-robin instance
        for (int i = 0; i < 17; i++) begin
            if_req = vecs[i].if_req; if_addr = vecs[i].if_addr;
            d_req = vecs[i].d_req; d_we = vecs[i].d_we;
            d_addr = vecs[i].d_addr; d_wdata = vecs[i].d_wdata;
            mem_ack = vecs[i].mem_ack; mem_rdata = vecs[i].mem_rdata;
            tick();
            chk($sformatf("v%0d mem_req", i), {31'd0, mem_req}, {31'd0, vecs[i].e_mem_req});
            chk($sformatf("v%0d sel", i), {31'd0, sel}, {31'd0, vecs[i].e_sel});
            chk($sformatf("v%0d mem_we", i), {31'd0, mem_we}, {31'd0, vecs[i].e_we});
            chk($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].e_addr);
            chk($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].e_wdata);
            chk($sformatf("v%0d if_ack", i), {31'd0, if_ack}, {31'd0, vecs[i].e_if_ack});
            chk($sformatf("v%0d d_ack", i), {31'd0, d_ack}, {31'd0, vecs[i].e_d_ack});
            chk($sformatf("v%0d if_rdata", i), if_rdata, vecs[i].e_if_rdata);
            chk($sformatf("v%0d d_rdata", i), d_rdata, vecs[i].e_d_rdata);
            chk($sformatf("v%0d busy", i), {31'd0, busy}, {31'd0, vecs[i].e_busy});
        end
        chk("table timeout_err", {31'd0, timeout_err}, 32'd0);

        // Tie from reset with both requests held and mem_ack always high
        do_reset();
        if_req = 1'b1; d_req = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("rr%0d grant sel", k), {31'd0, sel}, (k % 2 == 1) ? 32'd1 : 32'd0);
            chk($sformatf("rr%0d mem_req", k), {31'd0, mem_req}, 32'd1);
            chk($sformatf("df%0d grant sel", k), {31'd0, sel_1}, 32'd1);
            tick();
            chk($sformatf("rr%0d if_ack", k), {31'd0, if_ack}, (k % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("rr%0d d_ack", k), {31'd0, d_ack}, (k % 2 == 1) ? 32'd1 : 32'd0);
            tick();
            chk($sformatf("rr%0d idle", k), {31'd0, busy}, 32'd0);
        end

        // Data-first tie: D first, then IF once data drops its request
        do_reset();
        if_req = 1'b1; if_addr = 32'h40; d_req = 1'b1; d_addr = 32'h1000; mem_ack = 1'b1;
        tick();
        chk("df first sel", {31'd0, sel_1}, 32'd1);
        chk("df first addr", mem_addr_1, 32'h1000);
        tick();
        chk("df d_ack", {31'd0, d_ack_1}, 32'd1);
        d_req = 1'b0;
        tick();
        tick();
        chk("df second sel", {31'd0, sel_1}, 32'd0);
        chk("df second addr", mem_addr_1, 32'h40);
        tick();
        chk("df if_ack", {31'd0, if_ack_1}, 32'd1);

        // Watchdog: data read never acknowledged
        do_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4000;
        cycles = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (mem_req) cycles++;
            else break;
        end
        chk("to mem_req cycles", cycles, 32'd15);
        chk("to d_ack", {31'd0, d_ack}, 32'd1);
        chk("to d_rdata", d_rdata, 32'hDEADBEEF);
        chk("to timeout_err", {31'd0, timeout_err}, 32'd1);
        d_req = 1'b0;
        tick();
        chk("to d_ack pulse", {31'd0, d_ack}, 32'd0);
        if_req = 1'b1; if_addr = 32'h100;
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h600DDA7A;
        tick();
        chk("post-to if_ack", {31'd0, if_ack}, 32'd1);
        chk("post-to if_rdata", if_rdata, 32'h600DDA7A);
        if_req = 1'b0; mem_ack = 1'b0;
        tick();
        chk("sticky timeout_err", {31'd0, timeout_err}, 32'd1);

        // Asynchronous reset during BUSY_D, then a fresh grant
        do_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h5000;
        tick();
        tick();
        chk("pre-rst busy", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst mem_req", {31'd0, mem_req}, 32'd0);
        chk("async rst busy", {31'd0, busy}, 32'd0);
        chk("async rst sel", {31'd0, sel}, 32'd0);
        @(negedge clk);
        chk("async rst d_ack", {31'd0, d_ack}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("regrant sel", {31'd0, sel}, 32'd1);
        chk("regrant mem_addr", mem_addr, 32'h5000);
        mem_ack = 1'b1; mem_rdata = 32'h55AA55AA;
        tick();
        chk("regrant d_ack", {31'd0, d_ack}, 32'd1);
        chk("regrant d_rdata", d_rdata, 32'h55AA55AA);
        d_req = 1'b0; mem_ack = 1'b0;
        tick();
        chk("regrant idle", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
